// File: rtl/apb_lsu_pkg.sv
// Shared types and encodings for the APB3 load/store unit.
package apb_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] RC_OK       = 2'b00;
  localparam logic [1:0] RC_MISALIGN = 2'b01;
  localparam logic [1:0] RC_SLVERR   = 2'b10;
  localparam logic [1:0] RC_TIMEOUT  = 2'b11;

endpackage

// File: rtl/apb_lsu_lane.sv
// Byte-lane steering for the LSU: store shift, strobes, alignment check and
// load extraction with sign/zero extension.
module lsu_lane
  import apb_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]              addr_lo,
  input  logic [1:0]              size,
  input  logic                    write,
  input  logic                    is_unsigned,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  output logic                    misalign,
  output logic [DATA_WIDTH-1:0]   pdata,
  output logic [DATA_WIDTH/8-1:0] pstb,
  output logic [DATA_WIDTH-1:0]   ld_data
);

  localparam int STB_W = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(STB_W);

  logic [OFF_W-1:0] off;
  logic [OFF_W+2:0] shamt;
  logic [7:0]       mask;
  logic [63:0]      raw;
  logic [63:0]      ext;

  // Narrow values are extended in a 64-bit frame and truncated to the bus,
  // so on a 32-bit bus the unsigned flag cannot affect a word load.
  function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz,
                                         input logic uns);
    logic [63:0] r;
    case (sz)
      SZ_B:    r = {{56{~uns & v[7]}},  v[7:0]};
      SZ_H:    r = {{48{~uns & v[15]}}, v[15:0]};
      SZ_W:    r = {{32{~uns & v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    off   = addr_lo[OFF_W-1:0];
    shamt = {off, 3'b000};

    case (size)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = addr_lo[0];
      SZ_W:    misalign = |addr_lo[1:0];
      default: misalign = (DATA_WIDTH == 32) || (|addr_lo[2:0]);
    endcase

    case (size)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase

    pdata   = wdata << shamt;
    pstb    = write ? (STB_W'(mask) << off) : {STB_W{1'b1}};
    raw     = 64'(prdata >> shamt);
    ext     = extend(raw, size, is_unsigned);
    ld_data = ext[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/apb_lsu.sv
// APB3 load/store unit: one core request at a time through SETUP/ACCESS,
// with misalignment trapping and an optional slave-response timeout.
module apb_lsu
  import apb_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rts_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [1:0]              resp_code,
  output logic [ADDR_WIDTH-1:0]   APB_paddr,
  output logic                    APB_psel,
  output logic                    APB_penable,
  output logic                    APB_pwrite,
  output logic [DATA_WIDTH-1:0]   APB_pdata,
  output logic [DATA_WIDTH/8-1:0] APB_pstb,
  input  logic [DATA_WIDTH-1:0]   APB_prdata,
  input  logic                    APB_pready,
  input  logic                    APB_perr
);

  localparam int STB_W = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       addr_q;
  logic [1:0]       size_q;
  logic             write_q;
  logic             uns_q;

  logic             idle;
  logic [2:0]       lane_addr;
  logic [1:0]       lane_size;
  logic             lane_write;
  logic             lane_uns;
  logic             misalign;
  logic [DATA_WIDTH-1:0] lane_pdata;
  logic [STB_W-1:0]      lane_pstb;
  logic [DATA_WIDTH-1:0] ld_data;
  logic             timeout_hit;

  assign idle      = (state == IDLE);
  assign req_ready = idle;

  // Lane logic sees the live request while idle (to register SETUP values)
  // and the latched request afterwards (to extract load data).
  assign lane_addr  = idle ? req_addr[2:0] : addr_q;
  assign lane_size  = idle ? req_size      : size_q;
  assign lane_write = idle ? req_write     : write_q;
  assign lane_uns   = idle ? req_unsigned  : uns_q;

  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  lsu_lane #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane (
    .addr_lo     (lane_addr),
    .size        (lane_size),
    .write       (lane_write),
    .is_unsigned (lane_uns),
    .wdata       (req_wdata),
    .prdata      (APB_prdata),
    .misalign    (misalign),
    .pdata       (lane_pdata),
    .pstb        (lane_pstb),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      uns_q       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      resp_code   <= RC_OK;
      APB_paddr   <= '0;
      APB_psel    <= 1'b0;
      APB_penable <= 1'b0;
      APB_pwrite  <= 1'b0;
      APB_pdata   <= '0;
      APB_pstb    <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            addr_q  <= req_addr[2:0];
            size_q  <= req_size;
            write_q <= req_write;
            uns_q   <= req_unsigned;
            if (misalign) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_code  <= RC_MISALIGN;
              resp_rdata <= '0;
              state      <= RESP;
            end else begin
              APB_psel    <= 1'b1;
              APB_penable <= 1'b0;
              APB_paddr   <= req_addr;
              APB_pwrite  <= req_write;
              APB_pdata   <= lane_pdata;
              APB_pstb    <= lane_pstb;
              state       <= SETUP;
            end
          end
        end
        SETUP: begin
          APB_penable <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (APB_pready) begin
            APB_psel    <= 1'b0;
            APB_penable <= 1'b0;
            resp_valid  <= 1'b1;
            resp_err    <= APB_perr;
            resp_code   <= APB_perr ? RC_SLVERR : RC_OK;
            resp_rdata  <= (APB_perr || write_q) ? '0 : ld_data;
            state       <= RESP;
          end else if (timeout_hit) begin
            APB_psel    <= 1'b0;
            APB_penable <= 1'b0;
            resp_valid  <= 1'b1;
            resp_err    <= 1'b1;
            resp_code   <= RC_TIMEOUT;
            resp_rdata  <= '0;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_code  <= RC_OK;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_lsu.sv
// Directed bench for apb_lsu: 32-bit table of zero-wait transactions, timeout
// sequences, and a 64-bit instance for dword loads and mid-transfer reset.
module tb_apb_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // 32-bit instance, short timeout
  logic        rts_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_code;
  logic [31:0] paddr, pdata, prdata;
  logic        psel, penable, pwrite, pready, perr;
  logic [3:0]  pstb;

  apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4), .CNT_W(8)) dut32 (
    .clk(clk), .rts_n(rts_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_code(resp_code),
    .APB_paddr(paddr), .APB_psel(psel), .APB_penable(penable), .APB_pwrite(pwrite),
    .APB_pdata(pdata), .APB_pstb(pstb), .APB_prdata(prdata), .APB_pready(pready),
    .APB_perr(perr)
  );

  // 64-bit instance, default timeout
  logic        rts_n64;
  logic        req_valid64, req_ready64, req_write64, req_unsigned64;
  logic [31:0] req_addr64;
  logic [63:0] req_wdata64;
  logic [1:0]  req_size64;
  logic        resp_valid64, resp_err64;
  logic [63:0] resp_rdata64;
  logic [1:0]  resp_code64;
  logic [31:0] paddr64;
  logic [63:0] pdata64, prdata64;
  logic        psel64, penable64, pwrite64, pready64, perr64;
  logic [7:0]  pstb64;

  apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut64 (
    .clk(clk), .rts_n(rts_n64),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_write(req_write64),
    .req_addr(req_addr64), .req_wdata(req_wdata64), .req_size(req_size64),
    .req_unsigned(req_unsigned64),
    .resp_valid(resp_valid64), .resp_rdata(resp_rdata64), .resp_err(resp_err64),
    .resp_code(resp_code64),
    .APB_paddr(paddr64), .APB_psel(psel64), .APB_penable(penable64),
    .APB_pwrite(pwrite64), .APB_pdata(pdata64), .APB_pstb(pstb64),
    .APB_prdata(prdata64), .APB_pready(pready64), .APB_perr(perr64)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] prdata;
    logic        perr;
    logic        mis;
    logic [31:0] exp_pdata;
    logic [3:0]  exp_pstb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, ".req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns; prdata = v.prdata; perr = v.perr;
    pready = 1'b1;
    step();
    req_valid = 1'b0;
    if (v.mis) begin
      chk({t, ".mis_psel"}, psel, 0);
      chk({t, ".mis_resp_valid"}, resp_valid, 1);
      chk({t, ".mis_err"}, resp_err, 1);
      chk({t, ".mis_code"}, resp_code, v.exp_code);
    end else begin
      chk({t, ".setup_psel_pen"}, {psel, penable}, 2'b10);
      chk({t, ".paddr"}, paddr, v.addr);
      chk({t, ".pwrite"}, pwrite, v.wr);
      chk({t, ".pdata"}, pdata, v.exp_pdata);
      chk({t, ".pstb"}, pstb, v.exp_pstb);
      chk({t, ".setup_resp_valid"}, resp_valid, 0);
      step();
      chk({t, ".access_psel_pen"}, {psel, penable}, 2'b11);
      chk({t, ".access_pstb"}, pstb, v.exp_pstb);
      step();
      chk({t, ".resp_valid"}, resp_valid, 1);
      chk({t, ".resp_err"}, resp_err, v.exp_code != 2'b00);
      chk({t, ".resp_code"}, resp_code, v.exp_code);
      chk({t, ".resp_rdata"}, resp_rdata, v.exp_rdata);
      chk({t, ".resp_psel_pen"}, {psel, penable}, 2'b00);
    end
    step();
    chk({t, ".idle_resp_valid"}, resp_valid, 0);
    chk({t, ".idle_req_ready"}, req_ready, 1);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 32'h8000_0003, 32'h0000_00A5, 2'b00, 1'b0, 32'h0,          1'b0, 1'b0,
                32'hA500_0000, 4'b1000, 32'h0,          2'b00};
    vecs[1] = '{1'b0, 32'h8000_0002, 32'h0,         2'b01, 1'b0, 32'h8001_1234,  1'b0, 1'b0,
                32'h0,         4'b1111, 32'hFFFF_8001,  2'b00};
    vecs[2] = '{1'b0, 32'h8000_0002, 32'h0,         2'b01, 1'b1, 32'h8001_1234,  1'b0, 1'b0,
                32'h0,         4'b1111, 32'h0000_8001,  2'b00};
    vecs[3] = '{1'b0, 32'h8000_0006, 32'h0,         2'b10, 1'b0, 32'h0,          1'b0, 1'b1,
                32'h0,         4'b0000, 32'h0,          2'b01};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h0,         2'b11, 1'b0, 32'h0,          1'b0, 1'b1,
                32'h0,         4'b0000, 32'h0,          2'b01};
    vecs[5] = '{1'b1, 32'h8000_0000, 32'h0000_BEEF, 2'b01, 1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0,
                32'h0000_BEEF, 4'b0011, 32'h0,          2'b10};
    vecs[6] = '{1'b0, 32'h8000_0001, 32'h0,         2'b00, 1'b0, 32'h0000_8000,  1'b0, 1'b0,
                32'h0,         4'b1111, 32'hFFFF_FF80,  2'b00};
    vecs[7] = '{1'b0, 32'h8000_0001, 32'h0,         2'b00, 1'b1, 32'h0000_8000,  1'b0, 1'b0,
                32'h0,         4'b1111, 32'h0000_0080,  2'b00};
    vecs[8] = '{1'b1, 32'h8000_0002, 32'h0000_CAFE, 2'b01, 1'b0, 32'h0,          1'b0, 1'b0,
                32'hCAFE_0000, 4'b1100, 32'h0,          2'b00};
    vecs[9] = '{1'b0, 32'h8000_0000, 32'h0,         2'b10, 1'b1, 32'h8765_4321,  1'b0, 1'b0,
                32'h0,         4'b1111, 32'h8765_4321,  2'b00};

    rts_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; prdata = '0; pready = 1'b0; perr = 1'b0;
    rts_n64 = 1'b0; req_valid64 = 1'b0; req_write64 = 1'b0; req_addr64 = '0;
    req_wdata64 = '0; req_size64 = '0; req_unsigned64 = 1'b0; prdata64 = '0;
    pready64 = 1'b0; perr64 = 1'b0;
    step(); step();
    chk("rst.psel_pen", {psel, penable}, 2'b00);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.resp_code", resp_code, 0);
    chk("rst.pstb", pstb, 0);
    chk("rst.req_ready", req_ready, 1);
    rts_n = 1'b1; rts_n64 = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run32(vecs[i], i);

    // Slave never answers: four ACCESS cycles, then timeout
    pready = 1'b0; perr = 1'b0; prdata = 32'h1234_5678;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0000; req_size = 2'b10;
    req_unsigned = 1'b0;
    step();
    req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (psel && penable) n++;
      else break;
    end
    chk("to.access_cycles", n, 4);
    chk("to.psel", psel, 0);
    chk("to.resp_valid", resp_valid, 1);
    chk("to.resp_code", resp_code, 2'b11);
    chk("to.resp_err", resp_err, 1);
    step();

    // pready arrives in the last allowed ACCESS cycle and wins
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step(); step(); step(); step();
    chk("to_edge.still_access", {psel, penable}, 2'b11);
    pready = 1'b1;
    step();
    chk("to_edge.resp_valid", resp_valid, 1);
    chk("to_edge.resp_code", resp_code, 2'b00);
    chk("to_edge.resp_rdata", resp_rdata, 32'h1234_5678);
    pready = 1'b0;
    step();

    // 64-bit bus: dword load
    prdata64 = 64'h0123_4567_89AB_CDEF; pready64 = 1'b1;
    req_valid64 = 1'b1; req_write64 = 1'b0; req_addr64 = 32'h8000_0008; req_size64 = 2'b11;
    req_unsigned64 = 1'b0;
    step();
    req_valid64 = 1'b0;
    chk("d64.pstb", pstb64, 8'hFF);
    step(); step();
    chk("d64.resp_valid", resp_valid64, 1);
    chk("d64.resp_code", resp_code64, 2'b00);
    chk("d64.rdata", resp_rdata64, 64'h0123_4567_89AB_CDEF);
    step();

    // 64-bit bus: upper-word load, signed then unsigned
    prdata64 = 64'h8000_0000_0000_0000;
    for (int u = 0; u < 2; u++) begin
      req_valid64 = 1'b1; req_addr64 = 32'h8000_0004; req_size64 = 2'b10;
      req_unsigned64 = u[0];
      step();
      req_valid64 = 1'b0;
      step(); step();
      chk($sformatf("w64_u%0d.rdata", u), resp_rdata64,
          u[0] ? 64'h0000_0000_8000_0000 : 64'hFFFF_FFFF_8000_0000);
      step();
    end

    // Reset during ACCESS drops the bus at once and issues no response
    pready64 = 1'b0;
    req_valid64 = 1'b1; req_addr64 = 32'h8000_0008; req_size64 = 2'b11;
    step();
    req_valid64 = 1'b0;
    step();
    chk("rst64.in_access", {psel64, penable64}, 2'b11);
    rts_n64 = 1'b0;
    #1;
    chk("rst64.psel_pen_async", {psel64, penable64}, 2'b00);
    step();
    chk("rst64.no_resp", resp_valid64, 0);
    rts_n64 = 1'b1;
    step();
    chk("rst64.req_ready", req_ready64, 1);
    chk("rst64.no_resp_after", resp_valid64, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_lsu.md
Name: apb_lsu

Overview:
- Parametrised APB3 load/store unit: the next-generation memory port for the microcoded RV32/RV64 cores.
- Accepts one core request at a time and runs the APB setup and access phases.
- Handles byte-lane placement, strobes, sign/zero extension, misalignment traps and a slave-response timeout.
- Sits between the core's microcode sequencer and the APB interconnect, replacing ad-hoc bus handling inside the core.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, bus data width; legal values 32 or 64
TIMEOUT, 255, max ACCESS cycles waiting for APB_pready; 0 disables the timeout
CNT_W, 8, timeout counter width; must satisfy TIMEOUT < 2**CNT_W

Ports:
clk  in  1  clock
rts_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  unit can accept a request (high only in IDLE)
req_write  in  1  1=store, 0=load
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
req_size  in  2  00=byte, 01=half, 10=word, 11=dword
req_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err  out  1  completion is an error
resp_code  out  2  00=ok, 01=misaligned/illegal size, 10=slave error, 11=timeout
APB_paddr  out  ADDR_WIDTH  byte address (unmodified req_addr)
APB_psel  out  1  select
APB_penable  out  1  enable (access phase)
APB_pwrite  out  1  write
APB_pdata  out  DATA_WIDTH  write data, lane-shifted
APB_pstb  out  DATA_WIDTH/8  write strobes
APB_prdata  in  DATA_WIDTH  read data
APB_pready  in  1  slave ready
APB_perr  in  1  slave error, valid with pready

Behaviour:
- Reset (async, rts_n=0): state IDLE. All registered outputs 0, including APB_psel and APB_penable. Timeout counter 0. Asserting reset mid-transfer drops psel/penable immediately; no response is issued.
- Clock domain: single clock clk, rising-edge; reset asynchronous, active-low (rts_n).
- req_ready = (state==IDLE), combinational.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: on req_valid, latch all request fields. Let off = addr[log2(DATA_WIDTH/8)-1:0].
  - Misaligned (addr not a multiple of 2**size) or size==11 with DATA_WIDTH==32: go to RESP with code 01; no APB activity.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - psel=1, penable=0, paddr=addr, pwrite=write.
  - pdata = wdata << (8*off).
  - pstb = writes: size mask ((1<<2**size)-1) << off; reads: all ones.
  - Then go to ACCESS.
- ACCESS:
  - psel=1, penable=1; address, data and strobes held stable.
  - Counter increments each cycle pready=0.
  - On pready: capture prdata and perr, go to RESP. Code 10 if perr, else 00.
  - If TIMEOUT!=0 and counter reaches TIMEOUT with pready still 0: deassert psel/penable, go to RESP with code 11.
  - pready and timeout in the same cycle: pready wins.
- RESP (1 cycle): resp_valid=1 with resp_err=(code!=00) and resp_code; psel=penable=0; then IDLE. A new request is accepted no earlier than the cycle after RESP.
- Load data: raw = prdata >> (8*off), truncated to 8/16/32/64 bits per size. Sign-extend from the top bit unless req_unsigned. For word on a 32-bit bus, req_unsigned has no effect.
- Latency with zero-wait slave: request accepted cycle T, SETUP T+1, ACCESS T+2, resp_valid T+3. Misaligned: resp_valid at T+1.
- Between transactions APB_psel=0 and APB_penable=0; pdata, pstb and paddr keep their last values.

Decomposition:
- Package apb_lsu_pkg:
  - state enum: IDLE, SETUP, ACCESS, RESP.
  - size encoding constants: SZ_B, SZ_H, SZ_W, SZ_D.
  - resp_code constants: RC_OK, RC_MISALIGN, RC_SLVERR, RC_TIMEOUT.
- One combinational sub-module, lsu_lane: lane shift, strobe generation and load extraction/extension. The FSM stays in apb_lsu.

Test Plan:
- DATA_WIDTH=32, store byte addr 0x80000003 wdata 0xA5, zero-wait → SETUP pdata=0xA5000000, pstb=4'b1000; resp_valid 3 cycles after accept, code 00.
- Load half addr 0x80000002, prdata=0x8001xxxx, signed → resp_rdata=0xFFFF8001; same with req_unsigned=1 → 0x00008001; pstb=4'b1111 during the read.
- Load word addr 0x80000006 → no psel, resp_valid next cycle, resp_err=1, code 01; size=11 on a 32-bit bus → code 01.
- pready held 0 with TIMEOUT=4 → exactly 4 ACCESS cycles, then psel=0, resp code 11; pready rising on the 4th cycle → code 00.
- Slave returns pready=1, perr=1 on a store → resp_err=1, code 10, resp_rdata=0.
- DATA_WIDTH=64, load dword addr 0x80000008, prdata=0x0123456789ABCDEF → resp_rdata equals prdata. Then assert rts_n=0 mid-ACCESS → psel/penable low immediately, no resp_valid, req_ready=1 after release.
